serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial add/subtract sequencer for the calculator datapath.
//  Accepts two W-bit operands over a valid/ready handshake.
//  Drives one external 1-bit adder cell LSB-first for W cycles, holding the running carry in a register.
//  Returns the W-bit result, carry-out and signed overflow over a second valid/ready handshake.
// PARAMETERS
//  W  8  operand/result width in bits (W >= 2)
// PORTS
//  clk         in   1  single clock; all state updates on rising edge
//  rst_n       in   1  synchronous active-low reset
//  in_valid    in   1  operand request valid
//  in_ready    out  1  controller can accept operands (IDLE only)
//  in_a        in   W  operand A
//  in_b        in   W  operand B
//  in_sub      in   1  1 = A-B, 0 = A+B
//  cell_a      out  1  bit of A presented to adder cell
//  cell_b      out  1  bit of B (inverted when sub) presented to cell
//  cell_cin    out  1  carry-in presented to cell
//  cell_s      in   1  cell sum (combinational from cell_a/b/cin, same cycle)
//  cell_cout   in   1  cell carry-out (combinational, same cycle)
//  out_valid   out  1  result valid
//  out_ready   in   1  consumer accepts result
//  out_sum     out  W  result
//  out_cout    out  1  final carry (sub: 1 = no borrow)
//  out_ovf     out  1  two's-complement overflow
//  busy        out  1  high in RUN or DONE
// BEHAVIOUR
//  States: IDLE -> RUN -> DONE -> IDLE. Encoding is free; no other states.
//  Reset (rst_n=0 at posedge), regardless of state, including mid-RUN:
//   state=IDLE; in_ready=1; out_valid=0; busy=0; out_sum=0; out_cout=0; out_ovf=0;
//   carry reg=0; bit index=0. Any in-flight operation is discarded.
//  IDLE:
//   in_ready=1. On in_valid&in_ready: latch A; latch B, or ~B when in_sub.
//   Set carry=in_sub, index=0, state RUN.
//  RUN (exactly W cycles, index 0..W-1):
//   in_ready=0; in_valid is ignored.
//   cell_a=A[index]; cell_b=Bx[index]; cell_cin=carry.
//   Each posedge: sum[index]<=cell_s; carry<=cell_cout; index++.
//   At index W-1 also record ovf = cell_cout XOR carry(into MSB); then state DONE.
//  DONE:
//   out_valid=1; out_sum/out_cout/out_ovf stable until handshake.
//   On out_ready: state IDLE next cycle; outputs keep their values, out_valid drops.
//   No new operand is accepted in DONE, even if out_ready and in_valid coincide.
//  Latency: accept at edge 0; out_valid high in the cycle after edge W.
//   Minimum 1 idle cycle between results: throughput is one op per W+2 cycles.
//  cell_a/cell_b/cell_cin are 0 outside RUN.
//  Arithmetic: modulo 2^W. out_cout is the carry out of bit W-1.
//   ovf is set when the operands (after B inversion) share a sign that differs from the result sign.
//  out_valid stays high indefinitely under backpressure; no data is overwritten.
// TESTING  (W=8, reference combinational full-adder cell model)
//  add 0x5A+0x33 -> out_sum=0x8D, cout=0, ovf=1, out_valid at cycle 9 after accept
//  add 0xFF+0x01 -> out_sum=0x00, cout=1, ovf=0 (wrap-around)
//  sub 0x10-0x01 -> out_sum=0x0F, cout=1; sub 0x00-0x01 -> 0xFF, cout=0; sub 0x80-0x01 -> 0x7F, ovf=1
//  hold out_ready=0 for 20 cycles in DONE; pulse in_valid during RUN/DONE -> result stable, in_ready=0, second op not taken
//  rst_n=0 at RUN index 4 -> next cycle IDLE, in_ready=1, out_valid=0; new op 0x01+0x01 -> 0x02
//  back-to-back ops with out_ready tied 1 -> accepts spaced exactly W+2 cycles, all results correct

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer.
// Takes two W-bit operands and drives one external full-adder cell LSB-first
// for W cycles, keeping the running carry in a register. It then returns the
// sum, the carry-out and the signed overflow flag over a valid/ready handshake.
//
//   state  | meaning
//   IDLE   | waiting for operands, in_ready high
//   RUN    | one bit per cycle through the external cell, index 0..W-1
//   DONE   | result presented, out_valid high until out_ready
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic         cell_a,
    output logic         cell_b,
    output logic         cell_cin,
    input  logic         cell_s,
    input  logic         cell_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         busy
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  bx_q, bx_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        bx_d        = bx_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    // Subtraction is A + ~B + 1: invert B here, and the +1
                    // enters as the initial carry.
                    a_d        = in_a;
                    bx_d       = in_sub ? ~in_b : in_b;
                    carry_d    = in_sub;
                    idx_d      = '0;
                    state_d    = S_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                sum_d[idx_q] = cell_s;
                carry_d      = cell_cout;
                idx_d        = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Here carry_q is the carry into the MSB.
                    ovf_d       = cell_cout ^ carry_q;
                    cout_d      = cell_cout;
                    idx_d       = '0;
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            bx_q        <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            bx_q        <= bx_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Cell drive: the selected operand bits and the carry, forced low outside RUN.
    always_comb begin
        cell_a   = 1'b0;
        cell_b   = 1'b0;
        cell_cin = 1'b0;
        if (state_q == S_RUN) begin
            cell_a   = a_q[idx_q];
            cell_b   = bx_q[idx_q];
            cell_cin = carry_q;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (W=8) with a combinational full-adder cell.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         cell_a, cell_b, cell_cin, cell_s, cell_cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout, out_ovf, busy;

    int n_cmp = 0;
    int n_bad = 0;

    serial_add_ctrl #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .cell_a(cell_a), .cell_b(cell_b), .cell_cin(cell_cin),
        .cell_s(cell_s), .cell_cout(cell_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .busy(busy)
    );

    // Reference full-adder cell.
    assign cell_s    = cell_a ^ cell_b ^ cell_cin;
    assign cell_cout = (cell_a & cell_b) | (cell_a & cell_cin) | (cell_b & cell_cin);

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    // Arithmetic model: integer add/subtract, carry from the 9-bit unsigned
    // total, overflow from the signed result leaving [-128,127].
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        res_t r;
        int   ua, ub, tot, sa, sb, st;
        ua = int'(a);
        ub = int'(b);
        tot = sub ? (ua + (255 - ub) + 1) : (ua + ub);
        r.sum  = 8'(tot % 256);
        r.cout = (tot >= 256);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        st = sub ? sa - sb : sa + sb;
        r.ovf = (st > 127) || (st < -128);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction: accept, W cycles of cell drive, result, handshake.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         output res_t r, output int lat);
        logic [7:0] bx;
        int w;
        bx = sub ? ~b : b;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_before_op", 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (lat < W) begin
                chk("cell_a", 32'(cell_a), 32'(a[lat]));
                chk("cell_b", 32'(cell_b), 32'(bx[lat]));
                if (lat == 0) chk("cell_cin0", 32'(cell_cin), 32'(sub));
            end
            @(posedge clk); #1; lat++;
        end
        r.sum = out_sum; r.cout = out_cout; r.ovf = out_ovf;
        chk("latency", 32'(lat), 32'(W));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
        chk("sum_kept", 32'(out_sum), 32'(r.sum));
    endtask

    initial begin
        vec_t tbl[7];
        res_t r, e;
        int   lat;
        logic [7:0] ra, rb;
        logic       rs;

        tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_cout", 32'(out_cout), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        chk("rst_cell", 32'({cell_a, cell_b, cell_cin}), 32'd0);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].sub, r, lat);
            chk($sformatf("tbl%0d_sum", i), 32'(r.sum), 32'(tbl[i].sum));
            chk($sformatf("tbl%0d_cout", i), 32'(r.cout), 32'(tbl[i].cout));
            chk($sformatf("tbl%0d_ovf", i), 32'(r.ovf), 32'(tbl[i].ovf));
        end

        // Random operations against the model
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            e = model(ra, rb, rs);
            do_op(ra, rb, rs, r, lat);
            chk($sformatf("rnd%0d_sum", i), 32'(r.sum), 32'(e.sum));
            chk($sformatf("rnd%0d_cout", i), 32'(r.cout), 32'(e.cout));
            chk($sformatf("rnd%0d_ovf", i), 32'(r.ovf), 32'(e.ovf));
        end

        // Backpressure, in_valid pulses during RUN and DONE must be ignored
        in_a = 8'h5A; in_b = 8'h33; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 8'h11; in_b = 8'h22;
        for (int i = 0; i < W; i++) begin
            chk("run_in_ready", 32'(in_ready), 32'd0);
            chk("run_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 3 == 0);
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_sum", 32'(out_sum), 32'h8D);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        chk("bp_ovf", 32'(out_ovf), 32'd1);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_not_taken_busy", 32'(busy), 32'd0);
        chk("bp_not_taken_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_idle_stays", 32'(busy), 32'd0);

        // Reset in the middle of RUN (index 4)
        in_a = 8'hF0; in_b = 8'h0F; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_sum", 32'(out_sum), 32'd0);
        chk("mid_rst_cell", 32'({cell_a, cell_b, cell_cin}), 32'd0);
        do_op(8'h01, 8'h01, 1'b0, r, lat);
        chk("post_rst_sum", 32'(r.sum), 32'h02);
        chk("post_rst_cout", 32'(r.cout), 32'd0);

        // Back-to-back with out_ready tied high
        begin
            res_t exp_q[$];
            int   acc_cyc[$];
            int   n_acc, n_res, cyc;
            logic acc, fin;
            n_acc = 0; n_res = 0; cyc = 0;
            out_ready = 1'b1;
            in_a = 8'($urandom_range(0, 255));
            in_b = 8'($urandom_range(0, 255));
            in_sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            while ((n_acc < 6 || n_res < 6) && cyc < 200) begin
                acc = in_valid && in_ready;
                fin = out_valid;
                if (acc) begin
                    exp_q.push_back(model(in_a, in_b, in_sub));
                    acc_cyc.push_back(cyc);
                    n_acc++;
                end
                if (fin) begin
                    if (exp_q.size() == 0) begin
                        chk("b2b_unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("b2b_sum", 32'(out_sum), 32'(e.sum));
                        chk("b2b_cout", 32'(out_cout), 32'(e.cout));
                        chk("b2b_ovf", 32'(out_ovf), 32'(e.ovf));
                    end
                    n_res++;
                end
                @(posedge clk); #1; cyc++;
                if (acc) begin
                    in_a = 8'($urandom_range(0, 255));
                    in_b = 8'($urandom_range(0, 255));
                    in_sub = 1'($urandom_range(0, 1));
                    if (n_acc >= 6) in_valid = 1'b0;
                end
            end
            in_valid = 1'b0;
            out_ready = 1'b0;
            chk("b2b_accepts", 32'(n_acc), 32'd6);
            chk("b2b_results", 32'(n_res), 32'd6);
            for (int i = 1; i < acc_cyc.size(); i++)
                chk("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(W + 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
